// File: rtl/sdram_write_burst.sv
// SDRAM write engine: drains 2-beat FIFO entries as continuous write bursts,
// breaking on row wrap or refresh and resuming at the saved word address.
module sdram_write_burst #(
    parameter int DQ_WIDTH    = 16,
    parameter int BANK_WIDTH  = 2,
    parameter int ROW_WIDTH   = 12,
    parameter int COL_WIDTH   = 8,
    parameter int COUNT_WIDTH = 24,
    parameter int T_RCD       = 2,
    parameter int T_WR        = 2,
    parameter int T_RP        = 2,
    localparam int MW = DQ_WIDTH / 8,
    localparam int AW = BANK_WIDTH + ROW_WIDTH + COL_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [2:0]                 command,
    output logic [ROW_WIDTH-1:0]       address,
    output logic [BANK_WIDTH-1:0]      bank,
    output logic [DQ_WIDTH-1:0]        data_out,
    output logic [MW-1:0]              data_mask,
    output logic                       idle,
    input  logic                       enable,
    input  logic [AW-1:0]              app_address,
    input  logic                       auto_refresh,
    output logic                       wait_for_refresh,
    input  logic [2*DQ_WIDTH+2*MW-1:0] fifo_data,
    output logic                       fifo_read,
    input  logic                       fifo_ready,
    output logic                       fifo_activate,
    input  logic [COUNT_WIDTH-1:0]     fifo_size,
    input  logic                       fifo_inactive,
    output logic                       write_done
);

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_TERM  = 3'b110;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam int         DLY_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ACTIVATE, S_WRITE_CMD, S_WRITE_HI, S_WRITE_LO, S_TERM, S_PRE
    } state_t;

    state_t                 state;
    logic [DLY_W-1:0]       delay;
    logic [COUNT_WIDTH-1:0] count;
    logic [AW-1:0]          write_addr;

    logic [DQ_WIDTH-1:0]    data_lo, data_hi;
    logic [MW-1:0]          mask_lo, mask_hi;
    logic [COL_WIDTH-1:0]   col;

    assign data_lo = fifo_data[DQ_WIDTH-1:0];
    assign data_hi = fifo_data[2*DQ_WIDTH-1:DQ_WIDTH];
    assign mask_lo = fifo_data[2*DQ_WIDTH+MW-1:2*DQ_WIDTH];
    assign mask_hi = fifo_data[2*DQ_WIDTH+2*MW-1:2*DQ_WIDTH+MW];
    assign col     = write_addr[COL_WIDTH-1:0];

    assign idle = (delay == '0) && (state == S_IDLE || state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            delay            <= '0;
            count            <= '0;
            write_addr       <= '0;
            command          <= CMD_NOP;
            address          <= '0;
            bank             <= '0;
            data_out         <= '0;
            data_mask        <= '0;
            fifo_read        <= 1'b0;
            fifo_activate    <= 1'b0;
            wait_for_refresh <= 1'b0;
            write_done       <= 1'b0;
        end else begin
            fifo_read        <= 1'b0;
            write_done       <= 1'b0;
            wait_for_refresh <= 1'b0;
            data_out         <= '0;
            command          <= CMD_NOP;
            if (delay != '0) begin
                delay <= delay - DLY_W'(1);
            end else begin
                case (state)
                    S_IDLE: begin
                        wait_for_refresh <= 1'b1;
                        if (enable || fifo_ready) begin
                            write_addr <= app_address;
                            state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (auto_refresh) begin
                            wait_for_refresh <= 1'b1;
                        end else if (!fifo_activate) begin
                            if (fifo_ready) begin
                                fifo_activate <= 1'b1;
                                count         <= fifo_size;
                            end else if (fifo_inactive && !enable) begin
                                state <= S_IDLE;
                            end
                        end else if (count == '0) begin
                            fifo_activate <= 1'b0;
                            write_done    <= 1'b1;
                            delay         <= DLY_W'(1);
                        end else begin
                            state <= S_ACTIVATE;
                        end
                    end
                    S_ACTIVATE: begin
                        command <= CMD_ACT;
                        bank    <= write_addr[AW-1:ROW_WIDTH+COL_WIDTH];
                        address <= write_addr[ROW_WIDTH+COL_WIDTH-1:COL_WIDTH];
                        delay   <= DLY_W'(T_RCD);
                        state   <= S_WRITE_CMD;
                    end
                    S_WRITE_CMD: begin
                        command    <= CMD_WRITE;
                        address    <= {{(ROW_WIDTH-COL_WIDTH){1'b0}}, col};
                        data_out   <= data_hi;
                        data_mask  <= mask_hi;
                        write_addr <= write_addr + AW'(2);
                        state      <= S_WRITE_LO;
                    end
                    S_WRITE_HI: begin
                        data_out   <= data_hi;
                        data_mask  <= mask_hi;
                        write_addr <= write_addr + AW'(2);
                        state      <= S_WRITE_LO;
                    end
                    S_WRITE_LO: begin
                        // write_addr already points past this entry, so col==0 means the row wrapped
                        data_out  <= data_lo;
                        data_mask <= mask_lo;
                        fifo_read <= 1'b1;
                        count     <= count - COUNT_WIDTH'(1);
                        if (count == COUNT_WIDTH'(1) || col == '0 || auto_refresh)
                            state <= S_TERM;
                        else
                            state <= S_WRITE_HI;
                    end
                    S_TERM: begin
                        command <= CMD_TERM;
                        delay   <= DLY_W'(T_WR);
                        state   <= S_PRE;
                    end
                    S_PRE: begin
                        command <= CMD_PRE;
                        delay   <= DLY_W'(T_RP);
                        state   <= S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_write_burst.sv
// Randomised bench for sdram_write_burst: a FIFO model feeds entries and the
// observed command/beat streams are compared with a burst-level reference.
module tb_sdram_write_burst;

    localparam int DQ = 32, MW = 4, BW = 2, RW = 12, CW = 8, CNTW = 24;
    localparam int TRCD = 2, TWR = 2, TRP = 2;
    localparam int AW = BW + RW + CW;
    localparam int ENT_W = 2 * DQ + 2 * MW;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, WR = 3'b100, TRM = 3'b110, PRE = 3'b010;

    logic              clk, rst_n;
    logic [2:0]        command;
    logic [RW-1:0]     address;
    logic [BW-1:0]     bank;
    logic [DQ-1:0]     data_out;
    logic [MW-1:0]     data_mask;
    logic              idle, enable, auto_refresh, wait_for_refresh;
    logic [AW-1:0]     app_address;
    logic [ENT_W-1:0]  fifo_data;
    logic              fifo_read, fifo_ready, fifo_activate, fifo_inactive, write_done;
    logic [CNTW-1:0]   fifo_size;

    sdram_write_burst #(
        .DQ_WIDTH(DQ), .BANK_WIDTH(BW), .ROW_WIDTH(RW), .COL_WIDTH(CW),
        .COUNT_WIDTH(CNTW), .T_RCD(TRCD), .T_WR(TWR), .T_RP(TRP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .address(address), .bank(bank),
        .data_out(data_out), .data_mask(data_mask), .idle(idle), .enable(enable),
        .app_address(app_address), .auto_refresh(auto_refresh),
        .wait_for_refresh(wait_for_refresh), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .fifo_ready(fifo_ready), .fifo_activate(fifo_activate), .fifo_size(fifo_size),
        .fifo_inactive(fifo_inactive), .write_done(write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]    cmd;
        logic [BW-1:0] bnk;
        logic [RW-1:0] adr;
        int            cyc;
    } cmd_ev_t;

    logic [ENT_W-1:0] fifo_mem[$];
    cmd_ev_t          cmd_q[$];
    logic [DQ+MW-1:0] beat_q[$];
    int rd_ptr = 0, pops = 0, dones = 0, act_high = 0, wfr_hold = 0, cyc = 0;
    int ref_at_pop = 0, ref_wait = 0;
    bit in_burst = 0, ref_done = 0;

    function automatic logic [ENT_W-1:0] entry_at(input int i);
        if (i < fifo_mem.size()) return fifo_mem[i];
        return '0;
    endfunction

    // Monitor plus FIFO / refresh responder; a pop seen here takes effect for the next edge
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            in_burst = 0;
        end else begin
            if (command != NOP) cmd_q.push_back('{command, bank, address, cyc});
            if (command == WR) in_burst = 1;
            else if (command == TRM) in_burst = 0;
            if (in_burst && (command == WR || command == NOP)) beat_q.push_back({data_mask, data_out});
            if (write_done) dones++;
            if (fifo_activate) begin
                act_high++;
                fifo_ready = 1'b0;
            end
            if (fifo_read) begin
                pops++;
                rd_ptr++;
            end
            fifo_data = entry_at(rd_ptr);
            if (ref_at_pop > 0 && !ref_done) begin
                if (!auto_refresh && pops == ref_at_pop) begin
                    auto_refresh = 1'b1;
                    ref_wait = 0;
                end else if (auto_refresh) begin
                    ref_wait++;
                    if (wait_for_refresh && fifo_activate) wfr_hold++;
                    if (wfr_hold >= 6 || ref_wait > 300) begin
                        auto_refresh = 1'b0;
                        ref_done = 1;
                    end
                end
            end
        end
    end

    function automatic logic [ENT_W-1:0] rand_entry();
        return {4'($urandom), 4'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    function automatic bit wraps_after(input logic [AW-1:0] a, input int j);
        logic [AW-1:0] e;
        e = a + AW'(2 * j);
        return e[CW-1:0] == '0;
    endfunction

    task automatic clear_obs(input int k);
        cmd_q.delete();
        beat_q.delete();
        rd_ptr = 0; pops = 0; dones = 0; act_high = 0; wfr_hold = 0;
        ref_at_pop = k; ref_done = 0;
    endtask

    task automatic start_txn(input logic [AW-1:0] a, input int k);
        @(negedge clk);
        clear_obs(k);
        fifo_data   = entry_at(0);
        app_address = a;
        fifo_size   = CNTW'(fifo_mem.size());
        fifo_ready  = 1'b1;
        enable      = 1'b1;
    endtask

    task automatic run_txn(input string name, input logic [AW-1:0] a, input int k);
        int n, s, guard;
        logic [AW-1:0] sa;
        cmd_ev_t exp_q[$];
        logic [DQ+MW-1:0] exp_b[$];
        n = fifo_mem.size();
        start_txn(a, k);
        guard = 0;
        while (act_high == 0 && guard < 50) begin @(negedge clk); guard++; end
        enable = 1'b0;
        check_eq({name, "/claim"}, 64'(act_high > 0), 64'd1);
        guard = 0;
        while (dones == 0 && guard < 3000) begin @(negedge clk); guard++; end
        check_eq({name, "/done_seen"}, 64'(dones > 0), 64'd1);
        guard = 0;
        while (!(idle && !fifo_activate) && guard < 30) begin @(negedge clk); guard++; end
        repeat (4) @(negedge clk);

        // Reference: split entries into bursts at row wraps and at the entry after the refresh trigger
        s = 0;
        for (int j = 1; j <= n; j++) begin
            bit refb;
            refb = (k > 0) && (j == k + 1) && !wraps_after(a, k);
            if (wraps_after(a, j) || refb || j == n) begin
                sa = a + AW'(2 * s);
                exp_q.push_back('{ACT, sa[AW-1:RW+CW], sa[RW+CW-1:CW], 0});
                exp_q.push_back('{WR, sa[AW-1:RW+CW], RW'(sa[CW-1:0]), 0});
                exp_q.push_back('{TRM, '0, '0, 0});
                exp_q.push_back('{PRE, '0, '0, 0});
                s = j;
            end
        end
        for (int j = 0; j < n; j++) begin
            logic [ENT_W-1:0] e;
            e = fifo_mem[j];
            exp_b.push_back({e[ENT_W-1:ENT_W-MW], e[2*DQ-1:DQ]});
            exp_b.push_back({e[ENT_W-MW-1:2*DQ], e[DQ-1:0]});
        end

        check_eq({name, "/n_cmds"}, 64'(cmd_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++) begin
            check_eq($sformatf("%s/cmd%0d", name, i), 64'(cmd_q[i].cmd), 64'(exp_q[i].cmd));
            if (exp_q[i].cmd == ACT || exp_q[i].cmd == WR) begin
                check_eq($sformatf("%s/bank%0d", name, i), 64'(cmd_q[i].bnk), 64'(exp_q[i].bnk));
                check_eq($sformatf("%s/addr%0d", name, i), 64'(cmd_q[i].adr), 64'(exp_q[i].adr));
            end
            if (i + 1 < cmd_q.size() && cmd_q[i].cmd == ACT && cmd_q[i+1].cmd == WR)
                check_eq($sformatf("%s/t_rcd%0d", name, i), 64'(cmd_q[i+1].cyc - cmd_q[i].cyc), 64'(TRCD + 1));
            if (i + 1 < cmd_q.size() && cmd_q[i].cmd == TRM && cmd_q[i+1].cmd == PRE)
                check_eq($sformatf("%s/t_wr%0d", name, i), 64'(cmd_q[i+1].cyc - cmd_q[i].cyc), 64'(TWR + 1));
        end
        check_eq({name, "/n_beats"}, 64'(beat_q.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < beat_q.size(); i++)
            check_eq($sformatf("%s/beat%0d", name, i), 64'(beat_q[i]), 64'(exp_b[i]));
        check_eq({name, "/pops"}, 64'(pops), 64'(n));
        check_eq({name, "/done_once"}, 64'(dones), 64'd1);
        check_eq({name, "/idle_end"}, 64'({idle, fifo_activate}), 64'b10);
        if (k > 0) check_eq({name, "/refresh_hold"}, 64'(wfr_hold >= 6), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "/command"}, 64'(command), 64'(NOP));
        check_eq({name, "/address"}, 64'(address), 64'd0);
        check_eq({name, "/bank"}, 64'(bank), 64'd0);
        check_eq({name, "/data_out"}, 64'(data_out), 64'd0);
        check_eq({name, "/data_mask"}, 64'(data_mask), 64'd0);
        check_eq({name, "/strobes"}, 64'({fifo_read, fifo_activate, wait_for_refresh, write_done}), 64'd0);
        check_eq({name, "/idle"}, 64'(idle), 64'd1);
    endtask

    task automatic fill(input int n);
        fifo_mem.delete();
        for (int i = 0; i < n; i++) fifo_mem.push_back(rand_entry());
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; enable = 1'b0; auto_refresh = 1'b0; app_address = '0;
        fifo_data = '0; fifo_ready = 1'b0; fifo_size = '0; fifo_inactive = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(4);  run_txn("single", AW'('h10), 0);
        fill(4);  run_txn("row_cross", AW'('hFC), 0);
        fill(8);  run_txn("refresh", AW'('h10), 2);
        fill(0);  run_txn("size0", AW'('h40), 0);
        check_eq("size0/act_pulse", 64'(act_high > 0), 64'd1);

        fifo_mem.delete();
        fifo_mem.push_back({4'hA, 4'h5, 32'h1234_5678, 32'h9ABC_DEF0});
        run_txn("mask", AW'('h20), 0);
        check_eq("mask/hi", 64'(beat_q.size() > 0 ? beat_q[0][DQ+MW-1:DQ] : 4'h0), 64'hA);
        check_eq("mask/lo", 64'(beat_q.size() > 1 ? beat_q[1][DQ+MW-1:DQ] : 4'h0), 64'h5);

        fill(4);  run_txn("top_roll", {AW{1'b1}} - AW'(3), 0);

        // Reset asserted in the cycle following the first pop (engine in WRITE_HI)
        fill(6);
        start_txn(AW'('h10), 0);
        guard = 0;
        while (!fifo_read && guard < 60) begin
            @(negedge clk);
            guard++;
            if (fifo_activate) enable = 1'b0;
        end
        check_eq("midrst/reached_pop", 64'(fifo_read), 64'd1);
        rst_n = 1'b0; enable = 1'b0; fifo_ready = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill(3);  run_txn("after_rst", AW'('h80), 0);

        for (int it = 0; it < 10; it++) begin
            logic [AW-1:0] a;
            int n, k;
            a = AW'($urandom) & ~AW'(1);
            if (it % 2 == 0) a[CW-1:0] = CW'(256 - 2 * $urandom_range(1, 6));
            n = $urandom_range(1, 12);
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
            fill(n);
            run_txn($sformatf("rand%0d", it), a, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
